uart_tx_fifo: RTL and testbench

Parametrised UART transmitter for the pipeline CPU's peripheral bus. It is the successor to the fixed 8N1 sender. It runs on the system clock with an internal baud divider instead of a separate sample clock. It supports configurable data width, parity and stop bits, and buffers outgoing bytes in an internal FIFO so the CPU can write back-to-back without polling between bytes.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared parity constants, FSM encoding and frame-length helper.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo                                                            |
// | Synchronous FIFO with extra-bit pointers; full/empty/count decoded   |
// | straight from the pointer flops.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Both qualifiers use pre-edge state, so a push while full is dropped
  // even when a pop happens on the same edge.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo                                                         |
// | FIFO-buffered UART transmitter with internal baud divider.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_BITS-1:0]     TX_DATA,
  input  logic                     TX_EN,
  output logic                     TX_FULL,
  output logic                     TX_STATUS,
  output logic [$clog2(DEPTH):0]   TX_COUNT,
  output logic                     UART_TX
);

  generate
    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $fatal(1, "uart_tx_fifo: illegal parameter combination");
    end
  endgenerate

  localparam int             CW          = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  C_CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [2:0]     C_LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]     C_LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic           C_PAR_INV   = (PARITY_MODE == PAR_ODD);

  tx_state_e              state_q;
  logic [CW-1:0]          baud_q;
  logic [CW-1:0]          baud_d;
  logic [2:0]             bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   tx_q;
  logic                   status_q;

  logic                   w_bit_end;
  logic                   w_pop;
  logic                   w_empty;
  logic [DATA_BITS-1:0]   w_head;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (TX_EN),
    .data_i  (TX_DATA),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (TX_FULL),
    .empty_o (w_empty),
    .count_o (TX_COUNT)
  );

  assign w_bit_end = (state_q != ST_IDLE) && (baud_q == C_CNT_MAX);
  assign baud_d    = (state_q == ST_IDLE || w_bit_end) ? '0 : baud_q + CW'(1);

  // A word leaves the FIFO either from IDLE or at the very end of the last
  // stop bit, which gives back-to-back frames without an idle gap.
  assign w_pop = !w_empty &&
                 ((state_q == ST_IDLE) ||
                  (state_q == ST_STOP && w_bit_end && bit_q == C_LAST_STOP));

  // The line register follows the pre-edge state, so every bit (start bit
  // included) is delayed uniformly by one cycle and keeps its full width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      status_q <= 1'b1;
    end else begin
      baud_q   <= baud_d;
      status_q <= (state_q == ST_IDLE) && w_empty;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (w_pop) begin
            shift_q <= w_head;
            par_q   <= ^w_head;
            bit_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          tx_q <= 1'b0;
          if (w_bit_end) state_q <= ST_DATA;
        end
        ST_DATA: begin
          tx_q <= shift_q[0];
          if (w_bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_q == C_LAST_DATA) begin
              bit_q   <= '0;
              state_q <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          tx_q <= par_q ^ C_PAR_INV;
          if (w_bit_end) state_q <= ST_STOP;
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (w_bit_end) begin
            if (bit_q == C_LAST_STOP) begin
              bit_q <= '0;
              if (w_pop) begin
                shift_q <= w_head;
                par_q   <= ^w_head;
                state_q <= ST_START;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign UART_TX   = tx_q;
  assign TX_STATUS = status_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_fifo                                                      |
// | Three configurations against a frame-timeline reference model.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int ND   = 3;
  localparam int MAXF = 1024;
  localparam int CDIV [ND] = '{4, 2, 4};
  localparam int DBT  [ND] = '{8, 8, 5};
  localparam int PARM [ND] = '{0, 1, 2};
  localparam int STB  [ND] = '{1, 1, 2};
  localparam int DEP  [ND] = '{4, 8, 8};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] en  = '0;
  logic [7:0] dv [ND];

  wire        tx0, tx1, tx2, st0, st1, st2, fu0, fu1, fu2;
  wire [2:0]  cnt_a;
  wire [3:0]  cnt_b, cnt_c;
  logic [2:0] w_tx, w_st, w_fu;
  assign w_tx = {tx2, tx1, tx0};
  assign w_st = {st2, st1, st0};
  assign w_fu = {fu2, fu1, fu0};

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .DEPTH(4)) dut_a (
    .clk(clk), .reset(rst), .TX_DATA(dv[0]), .TX_EN(en[0]), .TX_FULL(fu0),
    .TX_STATUS(st0), .TX_COUNT(cnt_a), .UART_TX(tx0));
  uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .DEPTH(8)) dut_b (
    .clk(clk), .reset(rst), .TX_DATA(dv[1]), .TX_EN(en[1]), .TX_FULL(fu1),
    .TX_STATUS(st1), .TX_COUNT(cnt_b), .UART_TX(tx1));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(5), .PARITY_MODE(2), .STOP_BITS(2), .DEPTH(8)) dut_c (
    .clk(clk), .reset(rst), .TX_DATA(dv[2][4:0]), .TX_EN(en[2]), .TX_FULL(fu2),
    .TX_STATUS(st2), .TX_COUNT(cnt_c), .UART_TX(tx2));

  always #5 clk = ~clk;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // Model: one record per accepted word (accept edge, first start-bit cycle).
  int         f_acc [ND][MAXF];
  int         f_st  [ND][MAXF];
  logic [7:0] f_d   [ND][MAXF];
  int         fn    [ND];
  int         flo   [ND];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int get_cnt(input int d);
    case (d)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  function automatic int flen(input int d);
    return frame_bits(DBT[d], PARM[d], STB[d]) * CDIV[d];
  endfunction

  function automatic int popped(input int d, input int t);
    int p = flo[d];
    for (int k = flo[d]; k < fn[d]; k++) if (f_st[d][k] - 1 <= t) p++;
    return p;
  endfunction

  function automatic logic bitval(input int d, input logic [7:0] v, input int b);
    if (b == 0) return 1'b0;
    if (b <= DBT[d]) return v[b-1];
    if (PARM[d] != PAR_NONE && b == DBT[d] + 1) return (^v) ^ (PARM[d] == PAR_ODD);
    return 1'b1;
  endfunction

  function automatic logic exp_tx(input int d, input int t);
    for (int k = flo[d]; k < fn[d]; k++)
      if (t >= f_st[d][k] && t < f_st[d][k] + flen(d))
        return bitval(d, f_d[d][k], (t - f_st[d][k]) / CDIV[d]);
    return 1'b1;
  endfunction

  function automatic logic exp_status(input int d, input int t);
    for (int k = flo[d]; k < fn[d]; k++)
      if (t >= f_acc[d][k] + 1 && t < f_st[d][k] + flen(d)) return 1'b0;
    return 1'b1;
  endfunction

  // Model update on each edge, then one compare of every DUT output.
  initial begin
    int pre, s, c;
    for (int d = 0; d < ND; d++) begin fn[d] = 0; flo[d] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < ND; d++) begin
        if (rst) begin
          fn[d] = 0; flo[d] = 0;
        end else if (en[d]) begin
          pre = fn[d] - popped(d, cyc - 1);
          if (pre < DEP[d] && fn[d] < MAXF) begin
            s = cyc + 2;
            if (fn[d] > 0 && f_st[d][fn[d]-1] + flen(d) > s) s = f_st[d][fn[d]-1] + flen(d);
            f_acc[d][fn[d]] = cyc;
            f_st[d][fn[d]]  = s;
            f_d[d][fn[d]]   = dv[d] & 8'((1 << DBT[d]) - 1);
            fn[d]++;
          end
        end
      end
      #1;
      for (int d = 0; d < ND; d++) begin
        if (rst) begin
          chk($sformatf("tx[%0d]", d), w_tx[d], 1);
          chk($sformatf("status[%0d]", d), w_st[d], 1);
          chk($sformatf("count[%0d]", d), get_cnt(d), 0);
          chk($sformatf("full[%0d]", d), w_fu[d], 0);
        end else begin
          c = fn[d] - popped(d, cyc);
          chk($sformatf("tx[%0d]", d), w_tx[d], exp_tx(d, cyc));
          chk($sformatf("status[%0d]", d), w_st[d], exp_status(d, cyc));
          chk($sformatf("count[%0d]", d), get_cnt(d), c);
          chk($sformatf("full[%0d]", d), w_fu[d], (c == DEP[d]));
          while (flo[d] < fn[d] && f_st[d][flo[d]] + flen(d) <= cyc) flo[d]++;
        end
      end
    end
  end

  task automatic put(input int d, input logic [7:0] v, output int e);
    en[d] = 1'b1;
    dv[d] = v;
    @(negedge clk);
    e = cyc;
    en[d] = 1'b0;
  endtask

  task automatic at(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 50000) begin @(negedge clk); g++; end
    if (cyc != c) begin
      n_chk++; n_fail++;
      $display("FAIL at_sync: cycle %0d, expected %0d", cyc, c);
    end
  endtask

  task automatic wait_idle();
    int g;
    repeat (3) @(negedge clk);
    g = 0;
    while (w_st != 3'b111 && g < 20000) begin @(negedge clk); g++; end
    if (g >= 20000) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: status %b, expected 111", w_st);
    end
  endtask

  initial begin
    int n0, n1, e, hi, lows, pct;
    logic [9:0] pat;
    int pcts [4] = '{3, 20, 60, 100};
    for (int d = 0; d < ND; d++) dv[d] = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx0, 1);
    chk("rst_status", st0, 1);
    chk("rst_full", fu0, 0);
    chk("rst_count", cnt_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 frame of 0xA5 on a divider of 4
    pat = {1'b1, 8'hA5, 1'b0};
    put(0, 8'hA5, n0);
    for (int i = 0; i < 10; i++) begin
      at(n0 + 2 + 4 * i + 1);
      chk($sformatf("t1_bit%0d", i), tx0, pat[i]);
    end
    at(n0 + 41); chk("t1_status_early", st0, 0);
    at(n0 + 42); chk("t1_status_rise", st0, 1);
    wait_idle();

    // Even parity (divider 2) and odd parity (5 data bits) on 0x07
    put(1, 8'h07, n0);
    put(2, 8'h07, n1);
    at(n0 + 20); chk("t2_even_par", tx1, 1);
    at(n0 + 23); chk("t2_b_status_early", st1, 0);
    at(n0 + 24); chk("t2_b_status_rise", st1, 1);
    at(n1 + 26); chk("t2_odd_par", tx2, 0);
    wait_idle();

    // Six writes into a depth-4 FIFO
    put(0, 8'h11, n0);
    for (int i = 1; i < 6; i++) put(0, 8'((i + 1) * 8'h11), e);
    chk("t3_full", fu0, 1);
    chk("t3_count", cnt_a, 4);
    at(n0 + 201); chk("t3_status_early", st0, 0);
    at(n0 + 202); chk("t3_status_rise", st0, 1);
    wait_idle();

    // Two stop bits between back-to-back 5-bit frames
    put(2, 8'h1F, n0);
    put(2, 8'h00, n1);
    at(n0 + 29); chk("t4_par", tx2, 0);
    at(n0 + 30);
    hi = 0;
    while (tx2 == 1'b1 && hi < 100) begin hi++; @(negedge clk); end
    chk("t4_gap", hi, 8);
    wait_idle();

    // Write while full exactly on the stop-end pop
    put(0, 8'h21, n0);
    for (int i = 1; i < 5; i++) put(0, 8'(8'h21 + i), e);
    at(n0 + 40);
    chk("t6_count_before", cnt_a, 4);
    chk("t6_full_before", fu0, 1);
    put(0, 8'h99, e);
    chk("t6_count_after", cnt_a, 3);
    chk("t6_full_after", fu0, 0);
    at(n0 + 201); chk("t6_status_early", st0, 0);
    at(n0 + 202); chk("t6_status_rise", st0, 1);
    wait_idle();

    // Asynchronous reset during data bit 3 with two words queued
    put(0, 8'h00, n0);
    put(0, 8'h12, e);
    put(0, 8'h34, e);
    at(n0 + 19);
    chk("t5_tx_before", tx0, 0);
    chk("t5_count_before", cnt_a, 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_tx_async", tx0, 1);
    chk("t5_count_async", cnt_a, 0);
    chk("t5_status_async", st0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (200) begin @(negedge clk); if (tx0 !== 1'b1) lows++; end
    chk("t5_quiet", lows, 0);
    chk("t5_status", st0, 1);

    // Randomised bursts on all three configurations
    for (int seg = 0; seg < 15; seg++) begin
      pct = pcts[$urandom_range(0, 3)];
      repeat (200) begin
        for (int d = 0; d < ND; d++) begin
          en[d] = ($urandom_range(0, 99) < pct);
          dv[d] = 8'($urandom);
        end
        @(negedge clk);
      end
      en = '0;
      if (seg % 3 == 2) wait_idle();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
